// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch unit: word width, PC stride,
// default reset vector and the all-zero NOP encoding.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  typedef logic [INSTR_W-1:0] instr_t;
endpackage

// File: rtl/fifo_instr.sv
// Small shift-register FIFO of {pc, instr} entries. Entry 0 is always the head,
// so the head is a plain register with no read mux behind it.
module fifo_instr #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     ent_q [DEPTH];
  logic [W-1:0]     ent_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d, wr_idx;
  logic             pop_ok, push_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign count = cnt_q;
  assign head  = ent_q[0];

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    ent_d  = ent_q;
    cnt_d  = cnt_q;
    wr_idx = cnt_q - CNT_W'(pop_ok);
    if (flush) begin
      cnt_d = '0;
    end else begin
      if (pop_ok) begin
        for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
      end
      // The write slot is computed after the shift so a simultaneous pop and
      // push lands the new word directly behind the surviving entries.
      if (push_ok) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == wr_idx) ent_d[i] = wdata;
        end
      end
      cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/unidad_fetch.sv
// Instruction fetch unit: owns the PC, issues 1-cycle-latency reads to
// instruction memory and presents fetched words with their PC over valid/ready.
module unidad_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = ADDR_W + INSTR_W;

  // Handshake: a word transfers on a cycle where instr_valid && instr_ready
  // and redirect is low; instr/instr_pc hold steady while valid waits on ready.

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              inflight_q, inflight_d;
  logic              kill_q, kill_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENT_W-1:0]  fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;
  logic              credit_ok;

  assign instr_valid = ~fifo_empty;
  assign instr       = fifo_head[INSTR_W-1:0];
  assign instr_pc    = fifo_head[ENT_W-1:INSTR_W];

  assign fifo_pop  = instr_valid & instr_ready & ~redirect;
  assign fifo_push = inflight_q & ~kill_q & (~fifo_full | fifo_pop);

  // Buffered plus in-flight words, net of this cycle's pop, must leave room
  // for the word a new request would bring back next cycle.
  assign occupancy = {1'b0, fifo_count}
                   + {{CNT_W{1'b0}}, inflight_q}
                   - {{CNT_W{1'b0}}, fifo_pop};
  assign credit_ok = occupancy < (CNT_W + 1)'(DEPTH);

  assign imem_req  = rst_n & ~halt & ~redirect & credit_ok;
  assign imem_addr = pc_q;

  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = imem_req;
    kill_d     = redirect;
    if (redirect) begin
      pc_d = redirect_pc & ~ADDR_W'(3);
    end else if (imem_req) begin
      pc_d  = pc_q + ADDR_W'(PC_STEP);
      tag_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  fifo_instr #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .wdata ({tag_q, imem_rdata}),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
